fe_prefetch_queue: RTL and testbench

//  Parametrised fetch stage with decoupling instruction queue; successor of single-latch fetch.

---
 rtl/fe_prefetch_queue.sv | 123 ++++++++++++
 tb/tb_fe_prefetch_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fe_prefetch_queue.sv
// Fetch stage with a decoupling instruction queue in front of decode.
// Drives a 1-cycle synchronous instruction memory; a branch redirect flushes everything.
module fe_prefetch_queue #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 16,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_addr,
  input  logic                         id_ready,
  output logic                         id_valid,
  output logic [INSTR_W-1:0]           id_instr,
  output logic [ADDR_W-1:0]            id_instr_addr,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PcStep  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_PC);
  localparam logic [CNT_W:0]    Depth   = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  addr_q  [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               push;
  logic               pop;

  // An in-flight request already owns a slot, so a response can never overflow.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};

  always_comb begin
    imem_req  = !reset && !redirect && (occupancy < Depth);
    imem_addr = pc_q;
    id_valid  = (count_q != '0);
    push      = inflight_q && !redirect;
    pop       = id_valid && id_ready && !redirect;
  end

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      pc_d     = redirect_addr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (imem_req) begin
        pc_d       = pc_q + PcStep;
        req_addr_d = pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= PcReset;
      req_addr_q <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Entry storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      addr_q[wr_ptr_q]  <= req_addr_q + PcStep;
    end
  end

  always_comb begin
    id_instr      = '0;
    id_instr_addr = '0;
    if (id_valid) begin
      id_instr      = instr_q[rd_ptr_q];
      id_instr_addr = addr_q[rd_ptr_q];
    end
    q_count = count_q;
  end

endmodule

// File: tb/tb_fe_prefetch_queue.sv
// Directed bench for fe_prefetch_queue: streaming, stall, reset, redirect and PC wrap.
// Memory model returns mem[a] = a ^ 16'hA5A5 one cycle after a request.
module tb_fe_prefetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_addr = '0;
  logic        id_ready = 1'b1;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_instr_addr;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_fail   = 0;

  fe_prefetch_queue #(
    .ADDR_W   (16),
    .INSTR_W  (16),
    .DEPTH    (4),
    .RESET_PC (16),
    .PC_STEP  (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_instr_addr (id_instr_addr),
    .q_count       (q_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= imem_addr ^ 16'hA5A5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    int issues;

    // Reset state
    step(); step();
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_instr", id_instr, 0);
    check("rst_iaddr", id_instr_addr, 0);
    check("rst_qcnt", q_count, 0);

    // Streaming with id_ready high
    reset = 1'b0;
    #1;
    check("s_req0", imem_req, 1);
    check("s_addr0", imem_addr, 16);
    step();
    check("s_addr1", imem_addr, 18);
    check("s_valid1", id_valid, 0);
    for (int c = 2; c < 9; c++) begin
      step();
      a = 16'(16 + 2 * (c - 2));
      check("s_addr", imem_addr, 16 + 2 * c);
      check("s_valid", id_valid, 1);
      check("s_iaddr", id_instr_addr, a + 16'd2);
      check("s_instr", id_instr, a ^ 16'hA5A5);
      check("s_qcnt", q_count, 1);
    end

    // Stall: fill to DEPTH, head held
    reset = 1'b1;
    id_ready = 1'b0;
    step();
    reset = 1'b0;
    #1;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      if (imem_req) issues++;
      if (c >= 2) check("stall_head", id_instr_addr, 18);
    end
    check("stall_issues", issues, 4);
    check("stall_qcnt", q_count, 4);
    check("stall_req", imem_req, 0);

    // Release: in-order pops, sequential fetch resumes without gaps
    id_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      a = 16'(16 + 2 * i);
      check("rel_valid", id_valid, 1);
      check("rel_iaddr", id_instr_addr, a + 16'd2);
      check("rel_instr", id_instr, a ^ 16'hA5A5);
    end

    // Reset mid-stream with a full queue
    id_ready = 1'b0;
    repeat (6) step();
    check("full_qcnt", q_count, 4);
    reset = 1'b1;
    step();
    check("mr_valid", id_valid, 0);
    check("mr_instr", id_instr, 0);
    check("mr_iaddr", id_instr_addr, 0);
    check("mr_qcnt", q_count, 0);
    check("mr_req", imem_req, 0);
    reset = 1'b0;
    #1;
    check("mr_pc", imem_addr, 16);
    check("mr_req1", imem_req, 1);

    // Redirect with 3 queued + 1 in flight
    repeat (4) step();
    check("rd_qcnt", q_count, 3);
    check("rd_req_pre", imem_req, 0);
    redirect = 1'b1;
    redirect_addr = 16'h0040;
    #1;
    check("rd_req", imem_req, 0);
    step();
    redirect = 1'b0;
    id_ready = 1'b1;
    #1;
    check("rd_qcnt0", q_count, 0);
    check("rd_valid0", id_valid, 0);
    check("rd_addr", imem_addr, 16'h0040);
    check("rd_req1", imem_req, 1);
    step();
    check("rd_stale", id_valid, 0);
    step();
    check("rd_valid2", id_valid, 1);
    check("rd_iaddr", id_instr_addr, 16'h0042);
    check("rd_instr", id_instr, 16'h0040 ^ 16'hA5A5);

    // Redirect and pop in the same cycle with a full queue
    id_ready = 1'b0;
    repeat (6) step();
    check("rp_qcnt", q_count, 4);
    id_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 16'h0100;
    #1;
    check("rp_valid", id_valid, 1);
    step();
    redirect = 1'b0;
    #1;
    check("rp_qcnt0", q_count, 0);
    check("rp_valid0", id_valid, 0);
    check("rp_addr", imem_addr, 16'h0100);
    step();
    check("rp_valid1", id_valid, 0);
    step();
    check("rp_iaddr", id_instr_addr, 16'h0102);
    check("rp_instr", id_instr, 16'h0100 ^ 16'hA5A5);
    check("rp_qcnt1", q_count, 1);

    // Back-to-back redirects: last one wins
    redirect = 1'b1;
    redirect_addr = 16'h0200;
    step();
    redirect_addr = 16'h0300;
    step();
    redirect = 1'b0;
    #1;
    check("bb_addr", imem_addr, 16'h0300);
    check("bb_qcnt", q_count, 0);
    step(); step();
    check("bb_iaddr", id_instr_addr, 16'h0302);

    // PC wrap at 0xFFFE
    redirect = 1'b1;
    redirect_addr = 16'hFFFE;
    step();
    redirect = 1'b0;
    #1;
    check("wr_addr0", imem_addr, 16'hFFFE);
    step();
    check("wr_addr1", imem_addr, 16'h0000);
    step();
    check("wr_valid", id_valid, 1);
    check("wr_iaddr", id_instr_addr, 16'h0000);
    check("wr_instr", id_instr, 16'hFFFE ^ 16'hA5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
